mem_align_unit: RTL and testbench

- Sits between the EX/MEM pipeline register and DataMemory. Converts byte-addressed RV32 load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into word-only DataMemory accesses.
- Performs byte-lane extraction with sign/zero extension on loads.
- Performs read-modify-write for sub-word stores.
- Splits accesses that cross a word boundary into two word accesses. Stalls the pipeline while it works.

---
 rtl/mem_align_unit.sv | 210 +++++++++++++++++++++
 tb/tb_mem_align_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_align_unit.sv
// Byte-addressed RV32 load/store front end for a word-only DataMemory: lane extraction,
// sub-word read-modify-write and word-boundary splitting. Optional macro: MISALIGN_TRAP_EN.
module mem_align_unit #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned WIDTH  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [WIDTH-1:0]  req_wdata,
  input  logic [2:0]        req_funct3,
  output logic              stall,
  output logic              resp_valid,
  output logic [WIDTH-1:0]  resp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [WIDTH-1:0]  mem_wdata,
  output logic [2:0]        mem_funct3,
  input  logic [WIDTH-1:0]  mem_rdata,
  output logic              misalign_exc
);

  typedef enum logic [2:0] {StIdle, StRd0, StRd1, StWr0, StWr1, StDone} state_e;

  function automatic logic [2:0] size_of(input logic [2:0] f3);
    logic [2:0] sz;
    case (f3[1:0])
      2'b00:   sz = 3'd1;
      2'b01:   sz = 3'd2;
      default: sz = 3'd4;
    endcase
    return sz;
  endfunction

  function automatic logic crosses(input logic [1:0] off, input logic [2:0] sz);
    return ({2'b00, off} + {1'b0, sz}) > 4'd4;
  endfunction

  state_e state_q, state_d;

  logic [ADDR_W-1:0] word_q, word_inc;
  logic [1:0]        off_q;
  logic [2:0]        f3_q;
  logic              write_q;
  logic [WIDTH-1:0]  wdata_q;
  logic [WIDTH-1:0]  buf0_q, buf1_q, resp_rdata_q;

  logic              req_ok, accept, req_full_word, finish;
  logic [2:0]        req_size, cur_size;
  logic              cur_cross;

  logic [WIDTH-1:0]   buf0_d, buf1_d, lane, load_data;
  logic [2*WIDTH-1:0] stream, store_data, bit_mask, merged;
  logic [7:0]         byte_mask;

  assign req_ok        = req_valid && (req_read ^ req_write);
  assign accept        = (state_q == StIdle) && req_ok;
  assign req_size      = size_of(req_funct3);
  assign req_full_word = req_write && (req_size == 3'd4) && (req_addr[1:0] == 2'b00);
  assign cur_size      = size_of(f3_q);
  assign cur_cross     = crosses(off_q, cur_size);
  assign word_inc      = word_q + ADDR_W'(1);
  assign finish        = (state_q inside {StRd0, StRd1, StWr0, StWr1}) && (state_d == StDone);

`ifdef MISALIGN_TRAP_EN
  logic req_trap, exc_q;
  assign req_trap = ((req_size == 3'd2) && (req_addr[1:0] == 2'd3)) ||
                    ((req_size == 3'd4) && (req_addr[1:0] != 2'd0));
  assign misalign_exc = exc_q && (state_q == StDone);
`else
  assign misalign_exc = 1'b0;
`endif

  assign mem_funct3 = 3'b010;
  assign resp_rdata = resp_rdata_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_ok) begin
          // A full aligned word store overwrites every lane, so no read is needed.
          state_d = req_full_word ? StWr0 : StRd0;
`ifdef MISALIGN_TRAP_EN
          if (req_trap) state_d = StDone;
`endif
        end
      end
      StRd0:   state_d = cur_cross ? StRd1 : (write_q ? StWr0 : StDone);
      StRd1:   state_d = write_q ? StWr0 : StDone;
      StWr0:   state_d = cur_cross ? StWr1 : StDone;
      StWr1:   state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    stall      = 1'b0;
    resp_valid = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    unique case (state_q)
      StIdle: stall = req_ok;
      StRd0: begin
        stall    = 1'b1;
        mem_read = 1'b1;
        mem_addr = word_q;
      end
      StRd1: begin
        stall    = 1'b1;
        mem_read = 1'b1;
        mem_addr = word_inc;
      end
      StWr0: begin
        stall     = 1'b1;
        mem_write = 1'b1;
        mem_addr  = word_q;
        mem_wdata = merged[WIDTH-1:0];
      end
      StWr1: begin
        stall     = 1'b1;
        mem_write = 1'b1;
        mem_addr  = word_inc;
        mem_wdata = merged[2*WIDTH-1:WIDTH];
      end
      StDone:  resp_valid = 1'b1;
      default: ;
    endcase
  end

  // Load path sees the word being read this cycle so the result can register on entry to DONE.
  always_comb begin
    buf0_d = (state_q == StRd0) ? mem_rdata : buf0_q;
    buf1_d = (state_q == StRd1) ? mem_rdata : buf1_q;
    stream = {buf1_d, buf0_d};
    lane   = stream[{off_q, 3'b000} +: WIDTH];
    case (f3_q)
      3'b000:  load_data = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_data = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_data = {24'h0, lane[7:0]};
      3'b101:  load_data = {16'h0, lane[15:0]};
      default: load_data = lane;
    endcase
  end

  always_comb begin
    case (cur_size)
      3'd1:    byte_mask = 8'h01;
      3'd2:    byte_mask = 8'h03;
      default: byte_mask = 8'h0F;
    endcase
    byte_mask  = byte_mask << off_q;
    bit_mask   = '0;
    for (int i = 0; i < 8; i++) begin
      bit_mask[i*8 +: 8] = {8{byte_mask[i]}};
    end
    store_data = {{WIDTH{1'b0}}, wdata_q} << {off_q, 3'b000};
    merged     = ({buf1_q, buf0_q} & ~bit_mask) | (store_data & bit_mask);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q       <= '0;
      off_q        <= '0;
      f3_q         <= '0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
      buf0_q       <= '0;
      buf1_q       <= '0;
      resp_rdata_q <= '0;
`ifdef MISALIGN_TRAP_EN
      exc_q        <= 1'b0;
`endif
    end else begin
      if (accept) begin
        word_q  <= req_addr[ADDR_W+1:2];
        off_q   <= req_addr[1:0];
        f3_q    <= req_funct3;
        write_q <= req_write;
        wdata_q <= req_wdata;
`ifdef MISALIGN_TRAP_EN
        exc_q   <= req_trap;
        if (req_trap) resp_rdata_q <= '0;
`endif
      end
      if (state_q == StRd0) buf0_q <= mem_rdata;
      if (state_q == StRd1) buf1_q <= mem_rdata;
      if (finish) resp_rdata_q <= write_q ? '0 : load_data;
    end
  end

endmodule

// File: tb/tb_mem_align_unit.sv
// Directed bench for mem_align_unit: word-memory model, response scoreboard, immediate assertions.
module tb_mem_align_unit;

  localparam int unsigned ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0, req_read = 1'b0, req_write = 1'b0;
  logic [ADDR_W+1:0] req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic [2:0]        req_funct3 = '0;
  logic              stall, resp_valid, mem_read, mem_write, misalign_exc;
  logic [31:0]       resp_rdata, mem_wdata, mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [2:0]        mem_funct3;

  logic [31:0] mem [64];

  typedef struct {
    logic [31:0] data;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [5:0]  rd_log[$];
  int          n_cmp = 0;
  int          n_err = 0;

  mem_align_unit #(.ADDR_W(ADDR_W), .WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_read     (req_read),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_funct3   (req_funct3),
    .stall        (stall),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .mem_addr     (mem_addr),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_wdata    (mem_wdata),
    .mem_funct3   (mem_funct3),
    .mem_rdata    (mem_rdata),
    .misalign_exc (misalign_exc)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Issues one request, then follows it to resp_valid with a bounded wait.
  task automatic run_req(input string tag, input logic rd, input logic wr, input logic [7:0] addr,
                         input logic [2:0] f3, input logic [31:0] wd, input logic [31:0] exp_data,
                         input int exp_lat, input int exp_rds, input int exp_wrs,
                         input logic exp_exc);
    exp_t e;
    int   k, nrd, nwr;
    logic done;
    @(posedge clk); #1;
    req_valid = 1'b1; req_read = rd; req_write = wr;
    req_addr = addr; req_funct3 = f3; req_wdata = wd;
    e.data = exp_data; e.lat = exp_lat;
    sb.push_back(e);
    @(negedge clk);
    check({tag, " stall@0"}, stall, 1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
    rd_log.delete();
    k = 1; nrd = 0; nwr = 0; done = 1'b0;
    while (!done && k <= 20) begin
      @(negedge clk);
      check({tag, " rd/wr mutex"}, mem_read & mem_write, 0);
      if (mem_read) begin nrd++; rd_log.push_back(mem_addr); end
      if (mem_write) nwr++;
      if (resp_valid) done = 1'b1;
      else k++;
    end
    n_cmp++;
    assert (done) else begin
      n_err++;
      $error("FAIL %s timeout: observed no resp_valid, expected one within 20 cycles", tag);
    end
    if (done) begin
      e = sb.pop_front();
      check({tag, " latency"}, k, e.lat);
      check({tag, " rdata"}, resp_rdata, e.data);
      check({tag, " stall@done"}, stall, 0);
      check({tag, " exc"}, misalign_exc, exp_exc);
      check({tag, " reads"}, nrd, exp_rds);
      check({tag, " writes"}, nwr, exp_wrs);
      @(negedge clk);
      check({tag, " resp pulse"}, resp_valid, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of run, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    check("rst stall", stall, 0);
    check("rst resp_valid", resp_valid, 0);
    check("rst mem_read", mem_read, 0);
    check("rst mem_write", mem_write, 0);
    check("rst resp_rdata", resp_rdata, 0);
    check("rst mem_addr", mem_addr, 0);
    check("rst mem_wdata", mem_wdata, 0);
    check("rst exc", misalign_exc, 0);
    check("mem_funct3", mem_funct3, 3'b010);
    @(negedge clk); rst_n = 1'b1;

    // Preload through aligned SW (never reads)
    run_req("sw w0", 0, 1, 8'h00, 3'b010, 32'h01020304, 0, 2, 0, 1, 0);
    run_req("sw w1", 0, 1, 8'h04, 3'b010, 32'h82345678, 0, 2, 0, 1, 0);
    run_req("sw w2", 0, 1, 8'h08, 3'b010, 32'hAABBCCDD, 0, 2, 0, 1, 0);
    run_req("sw w63", 0, 1, 8'hFC, 3'b010, 32'h05060708, 0, 2, 0, 1, 0);
    check("mem w0", mem[0], 32'h01020304);
    check("mem w1", mem[1], 32'h82345678);
    check("mem w2", mem[2], 32'hAABBCCDD);
    check("mem w63", mem[63], 32'h05060708);

    run_req("lw 04", 1, 0, 8'h04, 3'b010, 0, 32'h82345678, 2, 1, 0, 0);
    check("lw 04 rd addr", rd_log[0], 1);
    run_req("lb 07", 1, 0, 8'h07, 3'b000, 0, 32'hFFFFFF82, 2, 1, 0, 0);
    run_req("lbu 07", 1, 0, 8'h07, 3'b100, 0, 32'h00000082, 2, 1, 0, 0);
    run_req("lhu 04", 1, 0, 8'h04, 3'b101, 0, 32'h00005678, 2, 1, 0, 0);
    run_req("lh 06", 1, 0, 8'h06, 3'b001, 0, 32'hFFFF8234, 2, 1, 0, 0);
    run_req("lw f3=011", 1, 0, 8'h08, 3'b011, 0, 32'hAABBCCDD, 2, 1, 0, 0);

`ifndef MISALIGN_TRAP_EN
    run_req("lh 07 cross", 1, 0, 8'h07, 3'b001, 0, 32'hFFFFDD82, 3, 2, 0, 0);
    check("lh 07 rd0 addr", rd_log[0], 1);
    check("lh 07 rd1 addr", rd_log[1], 2);
`else
    run_req("lh 07 trap", 1, 0, 8'h07, 3'b001, 0, 32'h0, 1, 0, 0, 1);
`endif

    run_req("sb 05", 0, 1, 8'h05, 3'b000, 32'h000000EE, 0, 3, 1, 1, 0);
    check("sb 05 mem w1", mem[1], 32'h8234EE78);
    run_req("sw w1 again", 0, 1, 8'h04, 3'b010, 32'h82345678, 0, 2, 0, 1, 0);

`ifndef MISALIGN_TRAP_EN
    run_req("sw 06 cross", 0, 1, 8'h06, 3'b010, 32'h11223344, 0, 5, 2, 2, 0);
    check("sw 06 mem w1", mem[1], 32'h33445678);
    check("sw 06 mem w2", mem[2], 32'hAABB1122);
    run_req("sh ff wrap", 0, 1, 8'hFF, 3'b001, 32'h0000BEEF, 0, 5, 2, 2, 0);
    check("sh ff mem w63", mem[63], 32'hEF060708);
    check("sh ff mem w0", mem[0], 32'h010203BE);
    run_req("lh ff wrap", 1, 0, 8'hFF, 3'b001, 0, 32'hFFFFBEEF, 3, 2, 0, 0);
    check("lh ff rd1 addr", rd_log[1], 0);
`else
    run_req("sw 06 trap", 0, 1, 8'h06, 3'b010, 32'h11223344, 0, 1, 0, 0, 1);
    check("sw 06 trap w1", mem[1], 32'h82345678);
    check("sw 06 trap w2", mem[2], 32'hAABBCCDD);
`endif

    // Malformed requests: both or neither of read/write
    @(posedge clk); #1;
    req_valid = 1'b1; req_read = 1'b1; req_write = 1'b1; req_addr = 8'h04;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("both stall", stall, 0);
      check("both mem", {mem_read, mem_write}, 0);
    end
    req_read = 1'b0; req_write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("neither stall", stall, 0);
      check("neither resp", resp_valid, 0);
    end
    @(posedge clk); #1; req_valid = 1'b0;

`ifndef MISALIGN_TRAP_EN
    // Reset asserted during WR1 of a crossing store
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h06;
    req_funct3 = 3'b010; req_wdata = 32'hCAFEBABE;
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'b0;
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    check("rstmid in wr1", mem_write, 1);
    check("rstmid wr1 addr", mem_addr, 2);
    rst_n = 1'b0; #1;
    check("rstmid stall", stall, 0);
    check("rstmid mem_write", mem_write, 0);
    check("rstmid mem_read", mem_read, 0);
    check("rstmid resp", resp_valid, 0);
    check("rstmid mem_addr", mem_addr, 0);
    check("rstmid mem_wdata", mem_wdata, 0);
    @(posedge clk); #1;
    check("rstmid w2 kept", mem[2], 32'hAABB1122);
    check("rstmid w1 written", mem[1], 32'hBABE5678);
    @(negedge clk); rst_n = 1'b1;
    run_req("post rst lw 08", 1, 0, 8'h08, 3'b010, 0, 32'hAABB1122, 2, 1, 0, 0);
    run_req("post rst lw 04", 1, 0, 8'h04, 3'b010, 0, 32'hBABE5678, 2, 1, 0, 0);
`endif

    check("scoreboard drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
